// File: rtl/piso_fifo_rd_sequencer.sv
`default_nettype none
// ============================================================================
// piso_fifo_rd_sequencer : pops async-FIFO words and serialises them over valid/ready.
// Define PIPO_PARITY_EN to append an even-parity bit to every word.   Rev 1.0
// ============================================================================
module piso_fifo_rd_sequencer #(
   parameter int WIDTH     = 8,
   parameter int LSB_FIRST = 0,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_n_i,
   input  logic                 enable_i,
   input  logic                 fifo_empty_i,
   input  logic [WIDTH-1:0]     fifo_rdata_i,
   input  logic                 fifo_rd_error_i,
   output logic                 fifo_rd_en_o,
   output logic                 sdata_o,
   output logic                 svalid_o,
   input  logic                 sready_i,
   output logic                 sof_o,
   output logic                 eof_o,
   output logic                 busy_o,
   output logic [CNT_WIDTH-1:0] words_sent_o,
   output logic [7:0]           rd_err_cnt_o
);

   localparam int            BW       = $clog2(WIDTH + 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
`ifdef PIPO_PARITY_EN
   localparam bit            HAS_PARITY = 1'b1;
`else
   localparam bit            HAS_PARITY = 1'b0;
`endif

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_LOAD   = 3'd2,
      S_SHIFT  = 3'd3,
      S_PARITY = 3'd4
   } state_t;

   state_t                 state_q;
   logic [WIDTH-1:0]       shreg_q;
   logic [BW-1:0]          bit_cnt_q;
   logic                   rd_en_q;
   logic                   sdata_q;
   logic                   svalid_q;
   logic                   sof_q;
   logic                   eof_q;
   logic                   busy_q;
   logic [CNT_WIDTH-1:0]   words_q;
   logic [7:0]             rd_err_cnt_q;
`ifdef PIPO_PARITY_EN
   logic                   parity_q;
`endif

   logic [WIDTH-1:0]       shreg_d;
   logic                   start_ok;

   assign shreg_d  = (LSB_FIRST != 0) ? (shreg_q >> 1) : (shreg_q << 1);
   assign start_ok = enable_i && !fifo_empty_i;

   function automatic logic out_bit(input logic [WIDTH-1:0] w);
      return (LSB_FIRST != 0) ? w[0] : w[WIDTH-1];
   endfunction

   // Outputs are registered alongside the state so they change only on clock edges.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q      <= S_IDLE;
         shreg_q      <= '0;
         bit_cnt_q    <= '0;
         rd_en_q      <= 1'b0;
         sdata_q      <= 1'b0;
         svalid_q     <= 1'b0;
         sof_q        <= 1'b0;
         eof_q        <= 1'b0;
         busy_q       <= 1'b0;
         words_q      <= '0;
         rd_err_cnt_q <= '0;
`ifdef PIPO_PARITY_EN
         parity_q     <= 1'b0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start_ok) begin
                  state_q <= S_FETCH;
                  rd_en_q <= 1'b1;
                  busy_q  <= 1'b1;
               end
            end
            S_FETCH: begin
               rd_en_q <= 1'b0;
               state_q <= S_LOAD;
            end
            S_LOAD: begin
               if (fifo_rd_error_i) begin
                  if (rd_err_cnt_q != 8'hFF) rd_err_cnt_q <= rd_err_cnt_q + 8'd1;
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  shreg_q   <= fifo_rdata_i;
                  bit_cnt_q <= '0;
                  svalid_q  <= 1'b1;
                  sdata_q   <= out_bit(fifo_rdata_i);
                  sof_q     <= 1'b1;
                  eof_q     <= !HAS_PARITY && (LAST_BIT == '0);
`ifdef PIPO_PARITY_EN
                  parity_q  <= ^fifo_rdata_i;
`endif
                  state_q   <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               if (sready_i) begin
                  shreg_q   <= shreg_d;
                  bit_cnt_q <= bit_cnt_q + BW'(1);
                  sof_q     <= 1'b0;
                  if (bit_cnt_q == LAST_BIT) begin
`ifdef PIPO_PARITY_EN
                     sdata_q <= parity_q;
                     eof_q   <= 1'b1;
                     state_q <= S_PARITY;
`else
                     words_q  <= words_q + CNT_WIDTH'(1);
                     svalid_q <= 1'b0;
                     sdata_q  <= 1'b0;
                     eof_q    <= 1'b0;
                     if (start_ok) begin
                        state_q <= S_FETCH;
                        rd_en_q <= 1'b1;
                     end else begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                     end
`endif
                  end else begin
                     sdata_q <= out_bit(shreg_d);
                     eof_q   <= !HAS_PARITY && ((bit_cnt_q + BW'(1)) == LAST_BIT);
                  end
               end
            end
`ifdef PIPO_PARITY_EN
            S_PARITY: begin
               if (sready_i) begin
                  words_q  <= words_q + CNT_WIDTH'(1);
                  svalid_q <= 1'b0;
                  sdata_q  <= 1'b0;
                  eof_q    <= 1'b0;
                  if (start_ok) begin
                     state_q <= S_FETCH;
                     rd_en_q <= 1'b1;
                  end else begin
                     state_q <= S_IDLE;
                     busy_q  <= 1'b0;
                  end
               end
            end
`endif
            default: begin
               state_q  <= S_IDLE;
               svalid_q <= 1'b0;
               busy_q   <= 1'b0;
            end
         endcase
      end
   end

   assign fifo_rd_en_o = rd_en_q;
   assign sdata_o      = sdata_q;
   assign svalid_o     = svalid_q;
   assign sof_o        = sof_q;
   assign eof_o        = eof_q;
   assign busy_o       = busy_q;
   assign words_sent_o = words_q;
   assign rd_err_cnt_o = rd_err_cnt_q;

endmodule
`default_nettype wire
